mux: RTL and testbench
======================

# mux

Two-input, 1-bit-per-channel selector (WIDTH-generalised) with a clocked select monitor. The data path drives `out` from input channel `s`. It is combinational by default, or registered when compiled with the output-register option. It sits in glue logic wherever a two-way source choice is needed, and its select-activity counter is exposed for debug and coverage.

## Interface
Clock and reset: one clock; reset is synchronous and active-high, ports named `clk` and `rst`.

Parameters:
- `WIDTH`, default 1: bits per data channel.
- `CNT_W`, default 8: width of the select-change counter.

Ports:
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  synchronous, active-high reset.
- `in`  input  2*WIDTH  packed channels: channel 0 = `in[WIDTH-1:0]`, channel 1 = `in[2*WIDTH-1:WIDTH]`.
- `s`  input  1  select: 0 picks channel 0, 1 picks channel 1.
- `out`  output  WIDTH  selected channel.
- `sel_q`  output  1  value of `s` sampled at the last rising `clk` edge.
- `sel_changes`  output  CNT_W  saturating count of sampled select transitions.

## Operation
- Data path: `out` = `s ? in[2*WIDTH-1:WIDTH] : in[WIDTH-1:0]`.
  - Pure bitwise selection, no arithmetic.
  - `in` and `s` may change at any time.
- Select monitor, evaluated on each rising `clk` edge:
  - If `rst`=1: `sel_q`←0 and `sel_changes`←0.
  - Otherwise, `sel_q`←`s`.
  - If `s` ≠ `sel_q` and `sel_changes` < 2^CNT_W−1, then `sel_changes`←`sel_changes`+1.
  - At 2^CNT_W−1 the counter holds (saturates) and never wraps.
  - On the first edge after reset release, `s`=1 counts as one change, because `sel_q` reset to 0.
- Reset mid-operation clears the monitor on that edge regardless of `s`.
  - In default (combinational) mode the data path is unaffected by `rst`.
- Select glitches between clock edges are not counted; only sampled values count.

## Timing
- Default mode: `out` has zero-cycle latency, is purely combinational from `in` and `s`, and is independent of `clk` and `rst`.
- Monitor outputs:
  - `sel_q` and `sel_changes` are registered and reflect inputs sampled at the previous rising edge.
  - Reset values: `sel_q`=0, `sel_changes`=0.
- Registered mode (see Configuration):
  - `out` updates one cycle after `in`/`s` are sampled.
  - Reset value of `out` is 0.
- Simultaneous `rst` and select toggle: reset wins; the counter reads 0.

## Configuration
- Macro `MUX_OUT_REG_EN`.
- Undefined (default): `out` is combinational as specified above.
- Defined:
  - `out` is a WIDTH-bit register loaded on each rising `clk` edge with the selected channel.
  - `rst`=1 loads 0.
  - Latency is 1 cycle.
  - The monitor behaviour is identical in both modes.

## Test plan
- Truth table, default mode, WIDTH=1:
  - Sweep `in` 00→01→10→11 with `s`=0, then repeat with `s`=1.
  - Required: `out` = 0,1,0,1 for `s`=0 and 0,0,1,1 for `s`=1, valid immediately with no clock edge needed.
- Free-running stimulus:
  - Increment `in` every 1 time unit and toggle `s` every 2 time units for 20 time units.
  - Required: at every instant `out` == `in[s]`.
- Counter:
  - After reset, drive `s` pattern 1,0,1,1,0 over five edges.
  - Required: `sel_changes` = 1,2,3,3,4 and `sel_q` follows one edge behind.
- Saturation, CNT_W=2:
  - Toggle `s` every edge for 6 edges.
  - Required: `sel_changes` = 1,2,3,3,3,3.
- Reset mid-run:
  - Assert `rst` for one edge while `sel_changes`=5 and `s` toggles.
  - Required: next read `sel_q`=0, `sel_changes`=0; in default mode `out` still tracks `in[s]` throughout.
- Registered mode, `MUX_OUT_REG_EN` defined:
  - Apply `in`=2'b10, `s`=1.
  - Required: `out`=0 until the next edge, then 1.
  - Required: `rst` forces `out`=0 on the following edge.

Source files
------------

// File: rtl/mux.sv
// Two-way WIDTH-bit selector with a clocked select-activity monitor.
// Define MUX_OUT_REG_EN to register the data path (1-cycle latency).
module mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] in,
  input  logic               s,
  output logic [WIDTH-1:0]   out,
  output logic               sel_q,
  output logic [CNT_W-1:0]   sel_changes
);

  logic [WIDTH-1:0] w_sel;
  logic             w_change;
  logic             w_sat;
  logic             r_sel_q;
  logic [CNT_W-1:0] r_cnt;

  assign w_sel    = s ? in[2*WIDTH-1:WIDTH] : in[WIDTH-1:0];
  assign w_change = (s != r_sel_q);
  assign w_sat    = &r_cnt;

  // Only sampled select values count; the counter holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sel_q <= s;
      if (w_change && !w_sat)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sel_q       = r_sel_q;
  assign sel_changes = r_cnt;

`ifdef MUX_OUT_REG_EN
  logic [WIDTH-1:0] r_out;

  always_ff @(posedge clk) begin
    if (rst)
      r_out <= '0;
    else
      r_out <= w_sel;
  end

  assign out = r_out;
`else
  assign out = w_sel;
`endif

endmodule

// File: tb/tb_mux.sv
// Randomized self-checking bench for mux against a behavioural model.
// Two instances: WIDTH=1/CNT_W=8 and WIDTH=4/CNT_W=2 (saturation).
module tb_mux;

  logic       clk;
  logic       rst;
  logic       s;
  logic [1:0] in_a;
  logic [7:0] in_b;
  logic       out_a;
  logic [3:0] out_b;
  logic       sq_a;
  logic       sq_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_chk;
  int n_fail;

  int m_q;
  int m_ca;
  int m_cb;
  int m_oa;
  int m_ob;

  mux #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in_a), .s(s),
    .out(out_a), .sel_q(sq_a), .sel_changes(cnt_a)
  );

  mux #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in(in_b), .s(s),
    .out(out_b), .sel_q(sq_b), .sel_changes(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_a(input logic [1:0] v, input logic sv);
    return sv ? int'(v[1]) : int'(v[0]);
  endfunction

  function automatic int pick_b(input logic [7:0] v, input logic sv);
    return sv ? int'(v[7:4]) : int'(v[3:0]);
  endfunction

  task automatic check_mon();
    chk("sel_q_a", int'(sq_a), m_q);
    chk("sel_q_b", int'(sq_b), m_q);
    chk("cnt_a", int'(cnt_a), m_ca);
    chk("cnt_b", int'(cnt_b), m_cb);
  endtask

  task automatic check_out();
`ifdef MUX_OUT_REG_EN
    chk("out_a_reg", int'(out_a), m_oa);
    chk("out_b_reg", int'(out_b), m_ob);
`else
    chk("out_a", int'(out_a), pick_a(in_a, s));
    chk("out_b", int'(out_b), pick_b(in_b, s));
`endif
  endtask

  // Called at a falling edge: drive, check, take one rising edge, check.
  task automatic cyc(input logic r, input logic sv,
                     input logic [1:0] a, input logic [7:0] b);
    rst  = r;
    s    = sv;
    in_a = a;
    in_b = b;
    #1;
    check_out();
    @(posedge clk);
    if (r) begin
      m_q  = 0;
      m_ca = 0;
      m_cb = 0;
      m_oa = 0;
      m_ob = 0;
    end else begin
      if (int'(sv) != m_q) begin
        m_ca = (m_ca < 255) ? m_ca + 1 : m_ca;
        m_cb = (m_cb < 3) ? m_cb + 1 : m_cb;
      end
      m_q  = int'(sv);
      m_oa = pick_a(a, sv);
      m_ob = pick_b(b, sv);
    end
    #1;
    check_mon();
    check_out();
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] pat;
    n_chk  = 0;
    n_fail = 0;
    m_q = 0; m_ca = 0; m_cb = 0; m_oa = 0; m_ob = 0;
    rst = 1'b1; s = 1'b0; in_a = '0; in_b = '0;
    @(negedge clk);
    cyc(1'b1, 1'b1, 2'b11, 8'hff);
    cyc(1'b1, 1'b0, 2'b00, 8'h00);

    // Truth table sweep with monitor held in reset
    for (int sv = 0; sv < 2; sv++)
      for (int v = 0; v < 4; v++)
        cyc(1'b1, sv[0], v[1:0], {v[3:0], 4'(~v)});

`ifndef MUX_OUT_REG_EN
    // Free-running inputs across clock edges, monitor in reset
    rst = 1'b1;
    for (int t = 0; t < 20; t++) begin
      in_a = t[1:0];
      in_b = {t[3:0], t[7:4]};
      s    = t[1];
      #1;
      chk("free_a", int'(out_a), pick_a(in_a, s));
      chk("free_b", int'(out_b), pick_b(in_b, s));
    end
    @(negedge clk);
    #1;
    check_mon();
    @(negedge clk);
`endif

    // Counter pattern 1,0,1,1,0 after reset
    cyc(1'b1, 1'b0, 2'b00, 8'h00);
    pat = 5'b01101;
    for (int i = 0; i < 5; i++)
      cyc(1'b0, pat[i], 2'($urandom), 8'($urandom));
    chk("pattern_cnt", int'(cnt_a), 4);

    // Saturation: toggle every edge for 6 edges
    cyc(1'b1, 1'b0, 2'b00, 8'h00);
    for (int i = 0; i < 6; i++)
      cyc(1'b0, ~i[0], 2'($urandom), 8'($urandom));
    chk("sat_cnt", int'(cnt_b), 3);

    // Reset mid-run while select toggles
    cyc(1'b1, 1'b0, 2'b00, 8'h00);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, ~i[0], 2'($urandom), 8'($urandom));
    chk("pre_rst_cnt", int'(cnt_a), 5);
    cyc(1'b1, 1'b0, 2'($urandom), 8'($urandom));
    chk("post_rst_cnt", int'(cnt_a), 0);

    // Registered-mode directed case: in=10, s=1
    cyc(1'b0, 1'b1, 2'b10, 8'h5a);
    cyc(1'b1, 1'b1, 2'b10, 8'h5a);

    // Random traffic with occasional reset
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 15) == 0), 1'($urandom),
          2'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
